// File: rtl/blk_fill_responder.sv
// Memory-side responder for the cache block-fill path: accepts a block read,
// waits a fixed latency, then streams BLK_WORDS words with rlast on the final one.
module blk_fill_responder #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int BLK_WORDS = 4,
    parameter int LATENCY   = 2,
    localparam int IDX_W    = $clog2(BLK_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              ack,
    output logic              busy,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [IDX_W-1:0]  word_idx,
    output logic              rlast,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               rlast_q, rlast_d;

    logic [DATA_W-1:0]  mem [2**ADDR_W];
    logic [IDX_W-1:0]   nxt_idx;
    logic [ADDR_W-1:0]  rd_addr;

    // Array is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            lat_q    <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            idx_q    <= '0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            lat_q    <= lat_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            idx_q    <= idx_d;
            rlast_q  <= rlast_d;
        end
    end

    // base_q low bits are always zero, so OR-ing in the counter stays inside the block.
    always_comb begin
        nxt_idx = (state_q == BURST) ? idx_q + IDX_W'(1) : '0;
        rd_addr = base_q | ADDR_W'(nxt_idx);
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        lat_d    = lat_q;
        ack_d    = 1'b0;
        busy_d   = busy_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        idx_d    = idx_q;
        rlast_d  = rlast_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WAIT;
                    base_d  = addr & ~OFF_MASK;
                    lat_d   = LAT_W'(LATENCY - 1);
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d  = BURST;
                    rvalid_d = 1'b1;
                    rdata_d  = mem[rd_addr];
                    idx_d    = '0;
                    rlast_d  = 1'b0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            BURST: begin
                if (rlast_q) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    busy_d   = 1'b0;
                    idx_d    = '0;
                end else begin
                    idx_d   = nxt_idx;
                    rdata_d = mem[rd_addr];
                    rlast_d = (nxt_idx == IDX_W'(BLK_WORDS - 1));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign word_idx = idx_q;
    assign rlast    = rlast_q;

endmodule

// File: tb/tb_blk_fill_responder.sv
// Directed bench for blk_fill_responder: per-cycle vector table for the default
// configuration plus hand sequences for reset mid-burst and LATENCY=1/BLK_WORDS=8.
module tb_blk_fill_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       req = 1'b0;
    logic [7:0] addr = '0;
    logic       ack, busy, rvalid, rlast;
    logic [7:0] rdata;
    logic [1:0] word_idx;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;

    logic       req8 = 1'b0;
    logic [7:0] addr8 = '0;
    logic       ack8, busy8, rvalid8, rlast8;
    logic [7:0] rdata8;
    logic [2:0] word_idx8;
    logic       wr_en8 = 1'b0;
    logic [7:0] wr_addr8 = '0;
    logic [7:0] wr_data8 = '0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    blk_fill_responder #(.ADDR_W(8), .DATA_W(8), .BLK_WORDS(4), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr),
        .ack(ack), .busy(busy), .rvalid(rvalid), .rdata(rdata),
        .word_idx(word_idx), .rlast(rlast),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    blk_fill_responder #(.ADDR_W(8), .DATA_W(8), .BLK_WORDS(8), .LATENCY(1)) u_dut8 (
        .clk(clk), .reset(reset), .req(req8), .addr(addr8),
        .ack(ack8), .busy(busy8), .rvalid(rvalid8), .rdata(rdata8),
        .word_idx(word_idx8), .rlast(rlast8),
        .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8)
    );

    typedef struct {
        logic       req;
        logic [7:0] addr;
        logic       we;
        logic [7:0] wa;
        logic [7:0] wd;
        logic       ack;
        logic       busy;
        logic       rv;
        logic [7:0] rd;
        logic [1:0] idx;
        logic       last;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [7:0] a, input logic we,
                                input logic [7:0] wa, input logic [7:0] wd,
                                input logic e_ack, input logic e_busy, input logic e_rv,
                                input logic [7:0] e_rd, input logic [1:0] e_idx,
                                input logic e_last);
        vec_t v;
        v.req = r; v.addr = a; v.we = we; v.wa = wa; v.wd = wd;
        v.ack = e_ack; v.busy = e_busy; v.rv = e_rv; v.rd = e_rd;
        v.idx = e_idx; v.last = e_last;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        req = v.req; addr = v.addr;
        wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
        tick();
        chk({tag, ".ack"},    32'(ack),    32'(v.ack));
        chk({tag, ".busy"},   32'(busy),   32'(v.busy));
        chk({tag, ".rvalid"}, 32'(rvalid), 32'(v.rv));
        chk({tag, ".rlast"},  32'(rlast),  32'(v.last));
        if (v.rv) begin
            chk({tag, ".rdata"},    32'(rdata),    32'(v.rd));
            chk({tag, ".word_idx"}, 32'(word_idx), 32'(v.idx));
        end
    endtask

    task automatic write_main(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic write8(input logic [7:0] a, input logic [7:0] d);
        wr_en8 = 1'b1; wr_addr8 = a; wr_data8 = d;
        tick();
        wr_en8 = 1'b0;
    endtask

    // Standard 7-cycle burst on block 0x40 expecting the preload values.
    task automatic add_plain_burst(input logic [7:0] a);
        add(1, a,     0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 2'd0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 2'd0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 8'hA0, 2'd0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 8'hA1, 2'd1, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 8'hA2, 2'd2, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 8'hA3, 2'd3, 1);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 2'd0, 0);
    endtask

    initial begin
        // Basic fill, then the unaligned address 0x43 resolving to base 0x40.
        add_plain_burst(8'h40);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 2'd0, 0);
        add_plain_burst(8'h43);

        // req held high; addr moved to 0x80 mid-burst must not disturb the current burst.
        add(1, 8'h40, 0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 2'd0, 0);
        add(1, 8'h40, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 2'd0, 0);
        add(1, 8'h80, 0, 8'h00, 8'h00, 0, 1, 1, 8'hA0, 2'd0, 0);
        add(1, 8'h80, 0, 8'h00, 8'h00, 0, 1, 1, 8'hA1, 2'd1, 0);
        add(1, 8'h80, 0, 8'h00, 8'h00, 0, 1, 1, 8'hA2, 2'd2, 0);
        add(1, 8'h80, 0, 8'h00, 8'h00, 0, 1, 1, 8'hA3, 2'd3, 1);
        add(1, 8'h80, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 2'd0, 0);
        add(1, 8'h80, 0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 2'd0, 0);
        add(1, 8'h80, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 2'd0, 0);
        add(1, 8'h80, 0, 8'h00, 8'h00, 0, 1, 1, 8'hC0, 2'd0, 0);
        add(1, 8'h80, 0, 8'h00, 8'h00, 0, 1, 1, 8'hC1, 2'd1, 0);
        add(1, 8'h80, 0, 8'h00, 8'h00, 0, 1, 1, 8'hC2, 2'd2, 0);
        add(1, 8'h80, 0, 8'h00, 8'h00, 0, 1, 1, 8'hC3, 2'd3, 1);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 2'd0, 0);

        // Write collision on 0x42 returns old data; the next burst sees the new value.
        add(1, 8'h40, 0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 2'd0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 2'd0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 8'hA0, 2'd0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 8'hA1, 2'd1, 0);
        add(0, 8'h00, 1, 8'h42, 8'h55, 0, 1, 1, 8'hA2, 2'd2, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 8'hA3, 2'd3, 1);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 2'd0, 0);
        add(1, 8'h40, 0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 2'd0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 2'd0, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 8'hA0, 2'd0, 0);
        add(0, 8'h00, 1, 8'h43, 8'h66, 0, 1, 1, 8'hA1, 2'd1, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 8'h55, 2'd2, 0);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 8'h66, 2'd3, 1);
        add(0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 2'd0, 0);
        add(0, 8'h00, 1, 8'h42, 8'hA2, 0, 0, 0, 8'h00, 2'd0, 0);
        add(0, 8'h00, 1, 8'h43, 8'hA3, 0, 0, 0, 8'h00, 2'd0, 0);

        // Reset state of both instances.
        #2;
        chk("rst.ack",    32'(ack),      32'd0);
        chk("rst.busy",   32'(busy),     32'd0);
        chk("rst.rvalid", 32'(rvalid),   32'd0);
        chk("rst.rlast",  32'(rlast),    32'd0);
        chk("rst.rdata",  32'(rdata),    32'd0);
        chk("rst.idx",    32'(word_idx), 32'd0);
        chk("rst8.busy",  32'(busy8),    32'd0);
        chk("rst8.rvalid",32'(rvalid8),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int unsigned i = 0; i < 4; i++) write_main(8'h40 + 8'(i), 8'hA0 + 8'(i));
        for (int unsigned i = 0; i < 4; i++) write_main(8'h80 + 8'(i), 8'hC0 + 8'(i));
        for (int unsigned i = 0; i < 8; i++) write8(8'h40 + 8'(i), 8'hB0 + 8'(i));

        for (int unsigned n = 0; n < vecs.size(); n++) begin
            run_vec(vecs[n], $sformatf("vec%0d", n));
        end

        // Reset asserted mid-cycle while word 1 is on the bus.
        for (int unsigned n = 0; n < 4; n++) run_vec(vecs[n], $sformatf("pre_rst%0d", n));
        #2;
        reset = 1'b1;
        req = 1'b1; addr = 8'h40;
        #1;
        chk("midrst.ack",    32'(ack),      32'd0);
        chk("midrst.busy",   32'(busy),     32'd0);
        chk("midrst.rvalid", 32'(rvalid),   32'd0);
        chk("midrst.rlast",  32'(rlast),    32'd0);
        chk("midrst.rdata",  32'(rdata),    32'd0);
        chk("midrst.idx",    32'(word_idx), 32'd0);
        for (int unsigned n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("inrst%0d.rvalid", n), 32'(rvalid), 32'd0);
            chk($sformatf("inrst%0d.rlast", n),  32'(rlast),  32'd0);
        end
        reset = 1'b0;
        req = 1'b0;
        tick();
        for (int unsigned n = 0; n < 7; n++) run_vec(vecs[n], $sformatf("post_rst%0d", n));

        // LATENCY=1, BLK_WORDS=8 instance; unaligned 0x45 resolves to base 0x40.
        req8 = 1'b1; addr8 = 8'h45;
        tick();
        chk("p8.ack",    32'(ack8),    32'd1);
        chk("p8.busy",   32'(busy8),   32'd1);
        chk("p8.rvalid", 32'(rvalid8), 32'd0);
        req8 = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("p8w%0d.ack", i),    32'(ack8),      32'd0);
            chk($sformatf("p8w%0d.rvalid", i), 32'(rvalid8),   32'd1);
            chk($sformatf("p8w%0d.rdata", i),  32'(rdata8),    32'(8'hB0 + 8'(i)));
            chk($sformatf("p8w%0d.idx", i),    32'(word_idx8), i);
            chk($sformatf("p8w%0d.rlast", i),  32'(rlast8),    (i == 7) ? 32'd1 : 32'd0);
        end
        tick();
        chk("p8.end.busy",   32'(busy8),   32'd0);
        chk("p8.end.rvalid", 32'(rvalid8), 32'd0);
        chk("p8.end.rlast",  32'(rlast8),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blk_fill_responder.md
Name: blk_fill_responder

Overview:
- Memory-side responder for the cache controller's block-fill (miss) path.
- On an accepted block read request it waits a fixed access latency, then streams BLK_WORDS consecutive words from an internal memory array.
- The last word is flagged with rlast; this is the END signal the cache FSM waits on in its block-read state.
- Includes a single-cycle preload/write port so benches and write paths can fill the array.

Parameters:
ADDR_W, 8, word address width; array depth is 2**ADDR_W words
DATA_W, 8, data word width
BLK_WORDS, 4, words per block; power of two, 2..16
LATENCY, 2, cycles from accept edge to first data edge; must be >= 1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  block read request, level-sampled in IDLE
addr  input  ADDR_W  word address; low log2(BLK_WORDS) bits ignored (block-aligned)
ack  output  1  one-cycle pulse: request accepted
busy  output  1  high while a request is in progress
rvalid  output  1  rdata/word_idx valid this cycle
rdata  output  DATA_W  returned word
word_idx  output  log2(BLK_WORDS)  index of current word within block
rlast  output  1  high with the final word of the block (END)
wr_en  input  1  write strobe to memory array
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data

Behaviour:
- Reset (asynchronous):
  - State = IDLE; ack, busy, rvalid, rlast = 0; rdata = 0; word_idx = 0; counters = 0.
  - Memory contents are not reset.
  - Reset mid-burst aborts the burst immediately; no rlast is produced.
- All outputs are registered.
- States: IDLE, WAIT, BURST.
- IDLE:
  - At edge E0 with req=1: latch base = addr with low log2(BLK_WORDS) bits cleared; load latency counter; go to WAIT.
  - After E0: ack=1 for exactly one cycle; busy=1.
- WAIT:
  - Holds for LATENCY cycles after E0; ack is high only in the first of these.
  - At edge E(LATENCY): go to BURST with word counter i=0.
- BURST:
  - In the cycle after edge E(LATENCY+i): rvalid=1, rdata=mem[base+i], word_idx=i.
  - rlast=1 only when i=BLK_WORDS-1.
  - At edge E(LATENCY+BLK_WORDS): go to IDLE; rvalid, rlast, busy = 0.
  - rvalid is continuous for BLK_WORDS cycles; there is no backpressure.
- Address arithmetic:
  - base+i never crosses a block boundary; the low bits are simply the counter.
  - There is no wrap beyond the array.
- Requests while busy:
  - req is ignored while busy=1; it is not queued.
  - req still high in IDLE is accepted on the next edge.
  - Minimum spacing is one idle cycle between the rlast cycle and the next ack.
- Memory writes (wr_en):
  - Occur at any state on the rising edge.
  - Write and burst read to the same address at the same edge: rdata returns old data (read-before-write).
  - A write to a block word not yet read becomes visible when that word is read.
- LATENCY=1:
  - ack and the single WAIT cycle coincide.
  - First rvalid is in the cycle after E1.

Test Plan:
1. Basic fill:
   - Stimulus: preload mem[0x40..0x43]=0xA0..0xA3; pulse req with addr=0x40 at E0 (LATENCY=2).
   - Required: ack high after E0 only; rvalid after E2..E5 with rdata A0,A1,A2,A3 and word_idx 0..3; rlast only with A3; busy low after E6.
2. Unaligned address:
   - Stimulus: req with addr=0x43.
   - Required: data A0..A3 from base 0x40; word_idx starts at 0.
3. Back-to-back requests:
   - Stimulus: hold req=1 continuously, addr=0x40.
   - Required: second ack exactly one idle cycle after the first rlast cycle; a changed addr during the burst has no effect on the current burst.
4. Write collision:
   - Stimulus: during a burst, wr_en to 0x42 with 0x55 at the same edge that reads 0x42, then a second burst on 0x40.
   - Required: first burst returns A2 for word 2; second burst returns 0x55 for word 2.
5. Reset mid-burst:
   - Stimulus: assert reset asynchronously after word 1.
   - Required: all outputs 0 immediately with no rlast; after release, a new req returns the full block with preload data intact.
6. Parameter sweep:
   - Stimulus: LATENCY=1, BLK_WORDS=8.
   - Required: first rvalid after E1; 8 words; rlast on word_idx 7; busy low after E9.
